ex_mem_wb_pipe: RTL and testbench
=================================

Name: ex_mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage core.
- Drives the data-memory request handshake and stalls the front of the pipe while a load or store waits on memory.
- Produces the MEM/WB destination, write-enable and write-back value that the forwarding unit and register file consume.

Parameters:
- XLEN, 32, datapath width.
- MAX_WAIT, 16, memory wait cycles allowed before the sticky error flag sets.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble)
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_alu_result  in  XLEN  ALU result / memory address
- ex_store_data  in  XLEN  rs2 value for stores
- stall_out  out  1  hold IF/ID/EX this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  request is a store
- dmem_addr  out  XLEN  address
- dmem_wdata  out  XLEN  store data
- dmem_ready  in  1  request accepted this cycle; rdata valid this cycle for loads
- dmem_rdata  in  XLEN  load data
- mem_rd  out  5  EX/MEM rd
- mem_reg_write  out  1  mem_valid & mem_reg_write_q
- mem_is_load  out  1  mem_valid & mem_read_q, for the load-use hazard check
- mem_fwd_data  out  XLEN  EX/MEM ALU result
- wb_rd  out  5  MEM/WB rd
- wb_reg_write  out  1  wb_valid & wb_reg_write_q
- wb_data  out  XLEN  write-back value
- dmem_err  out  1  sticky: a wait exceeded MAX_WAIT
- stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset (rstn low, asynchronous):
  - All valids, rds, write-enables, data registers, stall_cycles, wait counter and dmem_err clear to 0.
  - All outputs read 0.
- mem_op = mem_valid & (mem_read_q | mem_write_q).
- dmem_req = mem_op, combinational.
  - dmem_we = mem_write_q.
  - dmem_addr = mem_alu_q.
  - dmem_wdata = mem_store_q.
- stall_out = mem_op & ~dmem_ready, combinational, same cycle.
- Each clock edge without stall:
  - EX/MEM loads all ex_* inputs; mem_valid <= ex_valid.
  - MEM/WB loads from EX/MEM: wb_valid <= mem_valid, wb_rd <= mem_rd.
  - wb_data <= mem_read_q ? dmem_rdata : mem_alu_q.
  - Stores and non-memory ops pass the ALU result into wb_data; stores have reg_write=0 from decode.
- Each clock edge with stall:
  - EX/MEM holds.
  - MEM/WB takes a bubble: wb_valid <= 0, other WB fields hold.
  - Upstream keeps ex_* stable while stall_out=1.
- Latency:
  - EX to WB outputs is 2 edges with no stall.
  - Each memory wait cycle adds 1.
- A zero-wait memory op (dmem_ready=1 in its first MEM cycle) never stalls.
- Wait counter:
  - Increments each cycle stall_out=1; clears when the op completes.
  - On reaching MAX_WAIT, dmem_err sets and stays set until reset. The pipe keeps waiting and is not aborted.
- stall_cycles increments every cycle stall_out=1 and saturates at 0xFFFFFFFF.
- Bubble in MEM (mem_valid=0):
  - dmem_req=0 and all qualified outputs are 0.
  - The rd fields keep their stale values but are ignored.
- rd=0 is passed through unfiltered; x0 filtering is the consumer's job.
- dmem_ready while dmem_req=0 is ignored.
- Reset asserted mid-stall:
  - Request drops at once, and dmem_err and the counters clear.
  - The memory side must tolerate the abandoned request.

Test Plan:
- ALU op: ex_valid=1, rd=5, reg_write=1, alu=0x10. After edge 1: mem_rd=5, mem_reg_write=1, mem_fwd_data=0x10. After edge 2: wb_rd=5, wb_data=0x10, wb_reg_write=1.
- Load, zero wait: mem_read, addr 0x100, dmem_ready=1 in the first MEM cycle, rdata=0xDEADBEEF. Required: stall_out=0 throughout; next edge wb_data=0xDEADBEEF.
- Load, 3 wait cycles: dmem_ready low for 3 cycles. Required:
  - stall_out=1 for exactly 3 cycles and EX/MEM holds.
  - wb_reg_write=0 for 3 cycles, then wb_data=rdata.
  - stall_cycles=3, dmem_err=0.
- Store: mem_write, addr 0x40, data 0x55, ready after 1 wait. Required: dmem_we=1, dmem_wdata=0x55, one stall cycle, wb_reg_write=0.
- Timeout: MAX_WAIT=4, dmem_ready held low for 6 cycles. Required: dmem_err rises after the 4th wait cycle, stays high after completion, and clears only on rstn.
- Reset mid-stall: rstn low during a wait. Required: dmem_req, stall_out, mem_reg_write, wb_reg_write and stall_cycles all read 0 immediately, before the next clk.

Source files
------------

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory handshake.
// Loads and stores hold the front of the pipe until memory reports ready.
module ex_mem_wb_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_is_load,
  output logic [XLEN-1:0] mem_fwd_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            dmem_err,
  output logic [31:0]     stall_cycles
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  // EX/MEM state
  logic            mem_valid;
  logic [4:0]      mem_rd_q;
  logic            mem_reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [XLEN-1:0] mem_alu_q;
  logic [XLEN-1:0] mem_store_q;

  // MEM/WB state
  logic            wb_valid;
  logic [4:0]      wb_rd_q;
  logic            wb_reg_write_q;
  logic [XLEN-1:0] wb_data_q;

  logic [WW-1:0]   wait_cnt;
  logic            mem_op;
  logic            stall;

  always_comb begin
    mem_op = mem_valid & (mem_read_q | mem_write_q);
    stall  = mem_op & ~dmem_ready;
  end

  assign stall_out     = stall;
  assign dmem_req      = mem_op;
  assign dmem_we       = mem_write_q;
  assign dmem_addr     = mem_alu_q;
  assign dmem_wdata    = mem_store_q;
  assign mem_rd        = mem_rd_q;
  assign mem_reg_write = mem_valid & mem_reg_write_q;
  assign mem_is_load   = mem_valid & mem_read_q;
  assign mem_fwd_data  = mem_alu_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_write  = wb_valid & wb_reg_write_q;
  assign wb_data       = wb_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid       <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_alu_q       <= '0;
      mem_store_q     <= '0;
    end else if (!stall) begin
      mem_valid       <= ex_valid;
      mem_rd_q        <= ex_rd;
      mem_reg_write_q <= ex_reg_write;
      mem_read_q      <= ex_mem_read;
      mem_write_q     <= ex_mem_write;
      mem_alu_q       <= ex_alu_result;
      mem_store_q     <= ex_store_data;
    end
  end

  // A stalled MEM stage hands WB a bubble; the data fields keep their last value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid       <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
    end else if (stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid       <= mem_valid;
      wb_rd_q        <= mem_rd_q;
      wb_reg_write_q <= mem_reg_write_q;
      wb_data_q      <= mem_read_q ? dmem_rdata : mem_alu_q;
    end
  end

  // The wait counter parks at MAX_WAIT so a very long wait cannot wrap it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt     <= '0;
      dmem_err     <= 1'b0;
      stall_cycles <= '0;
    end else if (stall) begin
      if (wait_cnt != WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + WW'(1);
      if (wait_cnt >= WW'(MAX_WAIT - 1))
        dmem_err <= 1'b1;
      if (stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: vector table, hand sequences, random run.
module tb_ex_mem_wb_pipe;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MW   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] ex_store_data;
  logic            stall_out;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic            mem_is_load;
  logic [XLEN-1:0] mem_fwd_data;
  logic [4:0]      wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_data;
  logic            dmem_err;
  logic [31:0]     stall_cycles;

  always #5 clk = ~clk;

  ex_mem_wb_pipe #(.XLEN(XLEN), .MAX_WAIT(MW)) dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_fwd_data(mem_fwd_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .dmem_err(dmem_err), .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] st);
    ex_valid      = v;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_alu_result = alu;
    ex_store_data = st;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bubble();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] st;
    logic [31:0] rdata;
    logic [31:0] exp_wb;
    logic        exp_rw;
  } vec_t;

  vec_t tbl[6];

  // Behavioural reference state for the random run
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_st;
  logic        w_valid, w_rw;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  int          waits;
  logic        m_err;
  logic [31:0] m_scyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic exp_stall, m_op, held;

    tbl[0] = '{5'd5,  1'b1, 1'b0, 1'b0, 32'h10,       32'h0,  32'h0,       32'h10,       1'b1};
    tbl[1] = '{5'd3,  1'b1, 1'b1, 1'b0, 32'h100,      32'h0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{5'd0,  1'b0, 1'b0, 1'b1, 32'h40,       32'h55, 32'h1234,    32'h40,       1'b0};
    tbl[3] = '{5'd0,  1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,  32'h0,       32'hFFFFFFFF, 1'b1};
    tbl[4] = '{5'd31, 1'b0, 1'b0, 1'b0, 32'hABCD,     32'h9,  32'h5,       32'hABCD,     1'b0};
    tbl[5] = '{5'd31, 1'b1, 1'b1, 1'b0, 32'h8,        32'h0,  32'h0,       32'h0,        1'b1};

    rstn = 1'b1;
    bubble();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #2 rstn = 1'b0;
    #1;
    check("reset ctrl", 64'({stall_out, dmem_req, dmem_we, mem_reg_write, mem_is_load,
                             wb_reg_write, dmem_err}), 64'd0);
    check("reset data", 64'(dmem_addr | dmem_wdata | mem_fwd_data | wb_data), 64'd0);
    check("reset rd",   64'({mem_rd, wb_rd}), 64'd0);
    check("reset cnt",  64'(stall_cycles), 64'd0);
    do_reset();

    // Vector table: each op followed by one bubble, zero-wait memory
    for (int i = 0; i < 6; i++) begin
      drive_ex(1'b1, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].alu, tbl[i].st);
      dmem_ready = 1'b0;
      step();
      check($sformatf("vec%0d mem", i),
            64'({mem_rd, mem_reg_write, mem_is_load, mem_fwd_data}),
            64'({tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].alu}));
      bubble();
      dmem_ready = 1'b1;
      dmem_rdata = tbl[i].rdata;
      #1;
      check($sformatf("vec%0d req", i), 64'({dmem_req, stall_out}),
            64'({tbl[i].mr | tbl[i].mw, 1'b0}));
      if (tbl[i].mw)
        check($sformatf("vec%0d store", i), 64'({dmem_we, dmem_addr, dmem_wdata}),
              64'({1'b1, tbl[i].alu, tbl[i].st}));
      step();
      check($sformatf("vec%0d wb", i), 64'({wb_rd, wb_reg_write, wb_data}),
            64'({tbl[i].rd, tbl[i].exp_rw, tbl[i].exp_wb}));
    end
    check("vec stall_cycles", 64'(stall_cycles), 64'd0);

    // Load with three wait cycles; the following ALU op is held in EX
    do_reset();
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    step();
    drive_ex(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ld3 stall%0d", i), 64'({stall_out, dmem_req, dmem_we, dmem_addr}),
            64'({1'b1, 1'b1, 1'b0, 32'h100}));
      step();
      check($sformatf("ld3 hold%0d", i), 64'({mem_rd, wb_reg_write}), 64'({5'd7, 1'b0}));
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    check("ld3 release", 64'(stall_out), 64'd0);
    step();
    check("ld3 wb", 64'({wb_rd, wb_reg_write, wb_data}), 64'({5'd7, 1'b1, 32'hCAFEF00D}));
    check("ld3 next mem", 64'(mem_rd), 64'd9);
    check("ld3 counts", 64'({dmem_err, stall_cycles}), 64'({1'b0, 32'd3}));
    bubble();
    step();
    check("ld3 alu wb", 64'({wb_rd, wb_reg_write, wb_data}), 64'({5'd9, 1'b1, 32'h77}));

    // Store with one wait cycle
    do_reset();
    drive_ex(1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'h40, 32'h55);
    step();
    bubble();
    #1;
    check("st req", 64'({stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata}),
          64'({1'b1, 1'b1, 1'b1, 32'h40, 32'h55}));
    step();
    check("st wait wb", 64'(wb_reg_write), 64'd0);
    dmem_ready = 1'b1;
    #1;
    check("st release", 64'(stall_out), 64'd0);
    step();
    check("st done", 64'({wb_reg_write, wb_data, stall_cycles}), 64'({1'b0, 32'h40, 32'd1}));

    // Timeout: six wait cycles with MAX_WAIT = 4
    do_reset();
    drive_ex(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    step();
    bubble();
    for (int i = 1; i <= 6; i++) begin
      #1;
      check($sformatf("to stall%0d", i), 64'(stall_out), 64'd1);
      step();
      check($sformatf("to err%0d", i), 64'(dmem_err), 64'(i >= 4));
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11;
    step();
    check("to done", 64'({dmem_err, stall_cycles, wb_data}), 64'({1'b1, 32'd6, 32'h11}));
    step();
    step();
    check("to sticky", 64'(dmem_err), 64'd1);
    rstn = 1'b0;
    #1;
    check("to reset clears", 64'(dmem_err), 64'd0);
    do_reset();

    // Reset asserted in the middle of a wait
    drive_ex(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    step();
    bubble();
    #1;
    check("rst pre", 64'({stall_out, mem_reg_write}), 64'({1'b1, 1'b1}));
    step();
    #2 rstn = 1'b0;
    #1;
    check("rst mid-stall", 64'({dmem_req, stall_out, mem_reg_write, wb_reg_write, dmem_err}),
          64'd0);
    check("rst mid-stall cnt", 64'(stall_cycles), 64'd0);
    do_reset();

    // Random run against the reference model
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0; m_alu = 0; m_st = 0;
    w_valid = 0; w_rw = 0; w_rd = 0; w_data = 0;
    waits = 0; m_err = 0; m_scyc = 0;
    held = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        int kind;
        kind = $urandom_range(0, 2);
        drive_ex($urandom_range(0, 3) != 0, 5'($urandom), (kind != 2) && $urandom_range(0, 1) == 1,
                 kind == 1, kind == 2, $urandom, $urandom);
      end
      dmem_ready = $urandom_range(0, 3) != 0;
      dmem_rdata = $urandom;
      #1;
      m_op      = m_valid && (m_mr || m_mw);
      exp_stall = m_op && !dmem_ready;
      check("rnd stall", 64'({stall_out, dmem_req}), 64'({exp_stall, m_op}));
      if (m_op)
        check("rnd dmem", 64'({dmem_we, dmem_addr}), 64'({m_mw, m_alu}));
      if (m_op && m_mw)
        check("rnd wdata", 64'(dmem_wdata), 64'(m_st));
      check("rnd mem", 64'({mem_rd, mem_reg_write, mem_is_load, mem_fwd_data}),
            64'({m_rd, m_valid && m_rw, m_valid && m_mr, m_alu}));
      check("rnd wb", 64'({wb_rd, wb_reg_write, wb_data}), 64'({w_rd, w_valid && w_rw, w_data}));
      check("rnd err", 64'({dmem_err, stall_cycles}), 64'({m_err, m_scyc}));
      step();
      if (exp_stall) begin
        waits++;
        if (waits >= int'(MW)) m_err = 1'b1;
        m_scyc++;
        w_valid = 1'b0;
      end else begin
        waits   = 0;
        w_valid = m_valid;
        w_rd    = m_rd;
        w_rw    = m_rw;
        w_data  = m_mr ? dmem_rdata : m_alu;
        m_valid = ex_valid; m_rd = ex_rd; m_rw = ex_reg_write;
        m_mr = ex_mem_read; m_mw = ex_mem_write; m_alu = ex_alu_result; m_st = ex_store_data;
      end
      held = exp_stall;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
